// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch-side, data-side and memory-side handshake signals
// around the unified memory port arbiter.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Instruction-fetch side
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_ack;
  // Data side
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ack;
  // Single-ported memory side
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  // Arbiter status
  logic              busy;

  // Arbiter view: serves the core requesters, drives the memory
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    output i_rdata, i_ack, d_rdata, d_ack, mem_req, mem_we, mem_addr, mem_wdata, busy
  );

  // Environment view: core requesters plus the memory itself
  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    input  i_rdata, i_ack, d_rdata, d_ack, mem_req, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the instruction-fetch side (read
// only) and the data side (read/write). Data wins over fetch, except that a
// fetch kept waiting through MAX_WAIT consecutive data grants is forced in.
// Every output is a register; the memory handshake is held until mem_ack.
module mem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4,
  parameter int WAIT_W   = 3
) (
  input  logic                clk,
  input  logic                reset,
  mem_port_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

  state_t              state_r;
  state_t              state_s;
  logic [WAIT_W-1:0]   starve_cnt_r;
  logic                mem_req_r;
  logic                mem_we_r;
  logic [ADDR_W-1:0]   mem_addr_r;
  logic [DATA_W-1:0]   mem_wdata_r;
  logic                i_ack_r;
  logic                d_ack_r;
  logic [DATA_W-1:0]   i_rdata_r;
  logic [DATA_W-1:0]   d_rdata_r;
  logic                busy_r;

  logic                i_elig_s;
  logic                d_elig_s;
  logic                grant_i_s;
  logic                grant_d_s;
  logic                done_s;

  // A requester whose ack is high this cycle still shows its old req; mask it.
  assign i_elig_s = bus.i_req & ~i_ack_r;
  assign d_elig_s = bus.d_req & ~d_ack_r;
  // mem_ack only counts while a request is actually outstanding.
  assign done_s   = (state_r != IDLE) & mem_req_r & bus.mem_ack;

  // Next-state and grant decision.
  always_comb begin
    state_s   = state_r;
    grant_i_s = 1'b0;
    grant_d_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (i_elig_s && (starve_cnt_r == MAX_WAIT_C)) begin
          grant_i_s = 1'b1;
          state_s   = BUSY_I;
        end else if (d_elig_s) begin
          grant_d_s = 1'b1;
          state_s   = BUSY_D;
        end else if (i_elig_s) begin
          grant_i_s = 1'b1;
          state_s   = BUSY_I;
        end else begin
          state_s   = IDLE;
        end
      end
      BUSY_I, BUSY_D: begin
        if (done_s) begin
          state_s = IDLE;
        end else begin
          state_s = state_r;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Starvation counter: counts data grants taken while a fetch is waiting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt_r <= {WAIT_W{1'b0}};
    end else if (grant_i_s) begin
      starve_cnt_r <= {WAIT_W{1'b0}};
    end else if (grant_d_s) begin
      if (!bus.i_req) begin
        starve_cnt_r <= {WAIT_W{1'b0}};
      end else if (starve_cnt_r == MAX_WAIT_C) begin
        starve_cnt_r <= MAX_WAIT_C;
      end else begin
        starve_cnt_r <= starve_cnt_r + WAIT_W'(1);
      end
    end
  end

  // Memory request registers: loaded on grant, held until completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_wdata_r <= {DATA_W{1'b0}};
    end else if (grant_i_s) begin
      mem_req_r   <= 1'b1;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= bus.i_addr;
    end else if (grant_d_s) begin
      mem_req_r   <= 1'b1;
      mem_we_r    <= bus.d_we;
      mem_addr_r  <= bus.d_addr;
      mem_wdata_r <= bus.d_wdata;
    end else if (done_s) begin
      mem_req_r   <= 1'b0;
    end
  end

  // Completion: one-cycle ack to the served side and capture of read data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i_ack_r   <= 1'b0;
      d_ack_r   <= 1'b0;
      i_rdata_r <= {DATA_W{1'b0}};
      d_rdata_r <= {DATA_W{1'b0}};
    end else begin
      i_ack_r <= done_s && (state_r == BUSY_I);
      d_ack_r <= done_s && (state_r == BUSY_D);
      if (done_s && (state_r == BUSY_I)) begin
        i_rdata_r <= bus.mem_rdata;
      end
      if (done_s && (state_r == BUSY_D) && !mem_we_r) begin
        d_rdata_r <= bus.mem_rdata;
      end
    end
  end

  // Busy flag tracks the state the FSM is entering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_r <= 1'b0;
    end else begin
      busy_r <= (state_s != IDLE);
    end
  end

  assign bus.mem_req   = mem_req_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign bus.i_ack     = i_ack_r;
  assign bus.d_ack     = d_ack_r;
  assign bus.i_rdata   = i_rdata_r;
  assign bus.d_rdata   = d_rdata_r;
  assign bus.busy      = busy_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a randomized run
// scored against a transaction-level reference model of the arbitration rules.
module tb_mem_port_arbiter;

  localparam int MAX_WAIT = 4;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MAX_WAIT(MAX_WAIT), .WAIT_W(3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: which side is being served (0 none, 1 fetch, 2 data)
  int          m_serving;
  int          m_starve;
  logic        m_mem_req, m_mem_we, m_i_ack, m_d_ack;
  logic [31:0] m_mem_addr, m_mem_wdata, m_i_rdata, m_d_rdata;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    bus.i_req = 1'b0; bus.i_addr = 32'h0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = 32'h0; bus.d_wdata = 32'h0;
    bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic model_reset();
    m_serving = 0; m_starve = 0;
    m_mem_req = 1'b0; m_mem_we = 1'b0; m_i_ack = 1'b0; m_d_ack = 1'b0;
    m_mem_addr = 32'h0; m_mem_wdata = 32'h0; m_i_rdata = 32'h0; m_d_rdata = 32'h0;
  endtask

  // One clock of the arbitration rules, using the inputs present at the edge.
  task automatic model_clock();
    logic nxt_i_ack, nxt_d_ack, i_elig, d_elig;
    int   winner;
    nxt_i_ack = 1'b0;
    nxt_d_ack = 1'b0;
    if (m_serving == 0) begin
      i_elig = bus.i_req && !m_i_ack;
      d_elig = bus.d_req && !m_d_ack;
      winner = 0;
      if (i_elig && m_starve == MAX_WAIT) winner = 1;
      else if (d_elig) winner = 2;
      else if (i_elig) winner = 1;
      if (winner == 1) begin
        m_serving = 1; m_mem_req = 1'b1; m_mem_we = 1'b0; m_mem_addr = bus.i_addr;
        m_starve = 0;
      end else if (winner == 2) begin
        m_serving = 2; m_mem_req = 1'b1; m_mem_we = bus.d_we;
        m_mem_addr = bus.d_addr; m_mem_wdata = bus.d_wdata;
        m_starve = bus.i_req ? ((m_starve < MAX_WAIT) ? m_starve + 1 : MAX_WAIT) : 0;
      end
    end else if (bus.mem_ack) begin
      if (m_serving == 1) begin
        nxt_i_ack = 1'b1; m_i_rdata = bus.mem_rdata;
      end else begin
        nxt_d_ack = 1'b1;
        if (!m_mem_we) m_d_rdata = bus.mem_rdata;
      end
      m_serving = 0;
      m_mem_req = 1'b0;
    end
    m_i_ack = nxt_i_ack;
    m_d_ack = nxt_d_ack;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.i_req = 1'b1; bus.d_req = 1'b1; bus.mem_ack = 1'b1;
    bus.mem_rdata = 32'hFFFF_FFFF;
    tick();
    n_cmp++; if (bus.mem_req !== 1'b0) begin n_bad++; $display("FAIL rst_mem_req: got %b want 0", bus.mem_req); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    n_cmp++; if ({bus.i_ack, bus.d_ack} !== 2'b00) begin n_bad++; $display("FAIL rst_acks: got %b want 00", {bus.i_ack, bus.d_ack}); end
    n_cmp++; if (bus.i_rdata !== 32'h0) begin n_bad++; $display("FAIL rst_i_rdata: got %h want 0", bus.i_rdata); end
    n_cmp++; if (bus.d_rdata !== 32'h0) begin n_bad++; $display("FAIL rst_d_rdata: got %h want 0", bus.d_rdata); end
    n_cmp++; if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== 65'h0) begin n_bad++; $display("FAIL rst_mem_fields: got %b %h %h want 0", bus.mem_we, bus.mem_addr, bus.mem_wdata); end
    n_cmp++; if (dut.starve_cnt_r !== 3'd0) begin n_bad++; $display("FAIL rst_starve: got %0d want 0", dut.starve_cnt_r); end
    apply_reset();
    tick();
    n_cmp++; if ({bus.mem_req, bus.busy} !== 2'b00) begin n_bad++; $display("FAIL rst_idle_after: got %b want 00", {bus.mem_req, bus.busy}); end
  endtask

  task automatic test_i_only();
    apply_reset();
    bus.i_req = 1'b1; bus.i_addr = 32'hD4; bus.mem_ack = 1'b1; bus.mem_rdata = 32'h2008_0005;
    tick();
    n_cmp++; if ({bus.mem_req, bus.mem_we, bus.busy} !== 3'b101) begin n_bad++; $display("FAIL i1_grant: req/we/busy got %b want 101", {bus.mem_req, bus.mem_we, bus.busy}); end
    n_cmp++; if (bus.mem_addr !== 32'hD4) begin n_bad++; $display("FAIL i1_addr: got %h want d4", bus.mem_addr); end
    n_cmp++; if (bus.i_ack !== 1'b0) begin n_bad++; $display("FAIL i1_early_ack: got %b want 0", bus.i_ack); end
    tick();
    n_cmp++; if ({bus.i_ack, bus.d_ack, bus.mem_req, bus.busy} !== 4'b1000) begin n_bad++; $display("FAIL i1_done: iack/dack/req/busy got %b want 1000", {bus.i_ack, bus.d_ack, bus.mem_req, bus.busy}); end
    n_cmp++; if (bus.i_rdata !== 32'h2008_0005) begin n_bad++; $display("FAIL i1_rdata: got %h want 20080005", bus.i_rdata); end
    bus.i_req = 1'b0; bus.mem_ack = 1'b0;
    tick();
    n_cmp++; if ({bus.i_ack, bus.mem_req} !== 2'b00) begin n_bad++; $display("FAIL i1_pulse: got %b want 00", {bus.i_ack, bus.mem_req}); end
  endtask

  task automatic test_d_over_i();
    apply_reset();
    bus.i_req = 1'b1; bus.i_addr = 32'hD5;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h10; bus.d_wdata = 32'hDEAD_BEEF;
    tick();
    n_cmp++; if ({bus.mem_req, bus.mem_we} !== 2'b11) begin n_bad++; $display("FAIL d2_grant: req/we got %b want 11", {bus.mem_req, bus.mem_we}); end
    n_cmp++; if (bus.mem_addr !== 32'h10 || bus.mem_wdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL d2_fields: got %h %h want 10 deadbeef", bus.mem_addr, bus.mem_wdata); end
    n_cmp++; if (dut.starve_cnt_r !== 3'd1) begin n_bad++; $display("FAIL d2_starve1: got %0d want 1", dut.starve_cnt_r); end
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hAAAA_5555;
    tick();
    n_cmp++; if ({bus.d_ack, bus.i_ack} !== 2'b10) begin n_bad++; $display("FAIL d2_dack: d/i got %b want 10", {bus.d_ack, bus.i_ack}); end
    n_cmp++; if (bus.d_rdata !== 32'h0) begin n_bad++; $display("FAIL d2_rdata_held: got %h want 0", bus.d_rdata); end
    bus.d_req = 1'b0; bus.mem_ack = 1'b0;
    tick();
    n_cmp++; if ({bus.mem_req, bus.mem_we, bus.d_ack} !== 3'b100 || bus.mem_addr !== 32'hD5) begin n_bad++; $display("FAIL d2_i_grant: req/we/dack %b addr %h want 100 d5", {bus.mem_req, bus.mem_we, bus.d_ack}, bus.mem_addr); end
    n_cmp++; if (dut.starve_cnt_r !== 3'd0) begin n_bad++; $display("FAIL d2_starve0: got %0d want 0", dut.starve_cnt_r); end
    bus.mem_ack = 1'b1;
    tick();
    n_cmp++; if (bus.i_ack !== 1'b1 || bus.i_rdata !== 32'hAAAA_5555) begin n_bad++; $display("FAIL d2_i_done: ack %b rdata %h want 1 aaaa5555", bus.i_ack, bus.i_rdata); end
    bus.i_req = 1'b0; bus.mem_ack = 1'b0;
    tick();
  endtask

  task automatic test_starvation_guard();
    int   ngrant;
    logic prev_req;
    logic got_i;
    apply_reset();
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h40;
    bus.i_req = 1'b1; bus.i_addr = 32'h80;
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h1;
    ngrant = 0;
    prev_req = 1'b0;
    for (int c = 0; c < 40 && ngrant < 5; c++) begin
      tick();
      if (bus.mem_req && !prev_req) begin
        got_i = (bus.mem_addr == 32'h80);
        n_cmp++;
        if (got_i !== (ngrant == 4)) begin n_bad++; $display("FAIL sg_side: grant %0d went to I=%b want I=%b", ngrant + 1, got_i, (ngrant == 4)); end
        n_cmp++;
        if (dut.starve_cnt_r !== ((ngrant == 4) ? 3'd0 : 3'(ngrant + 1))) begin n_bad++; $display("FAIL sg_starve: grant %0d got %0d want %0d", ngrant + 1, dut.starve_cnt_r, (ngrant == 4) ? 0 : ngrant + 1); end
        ngrant++;
      end
      prev_req = bus.mem_req;
      bus.i_req = !bus.d_ack;
    end
    n_cmp++;
    if (ngrant < 5) begin n_bad++; $display("FAIL sg_timeout: saw %0d grants want 5", ngrant); end
    bus.i_req = 1'b0; bus.d_req = 1'b0; bus.mem_ack = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_wait_states();
    apply_reset();
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h20;
    for (int c = 1; c <= 4; c++) begin
      tick();
      n_cmp++;
      if ({bus.mem_req, bus.busy, bus.d_ack} !== 3'b110 || bus.mem_addr !== 32'h20) begin n_bad++; $display("FAIL ws_hold c%0d: req/busy/ack %b addr %h want 110 20", c, {bus.mem_req, bus.busy, bus.d_ack}, bus.mem_addr); end
      if (c == 4) begin bus.mem_ack = 1'b1; bus.mem_rdata = 32'h1234_5678; end
    end
    tick();
    n_cmp++; if ({bus.d_ack, bus.mem_req, bus.busy} !== 3'b100) begin n_bad++; $display("FAIL ws_done: ack/req/busy got %b want 100", {bus.d_ack, bus.mem_req, bus.busy}); end
    n_cmp++; if (bus.d_rdata !== 32'h1234_5678) begin n_bad++; $display("FAIL ws_rdata: got %h want 12345678", bus.d_rdata); end
    bus.d_req = 1'b0; bus.mem_ack = 1'b0;
    tick();
    n_cmp++; if (bus.d_ack !== 1'b0) begin n_bad++; $display("FAIL ws_pulse: got %b want 0", bus.d_ack); end
  endtask

  task automatic test_ack_while_idle();
    apply_reset();
    bus.i_req = 1'b1; bus.i_addr = 32'h4; bus.mem_ack = 1'b1; bus.mem_rdata = 32'h1111_2222;
    tick(); tick();
    bus.i_req = 1'b0;
    tick();
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h8; bus.mem_rdata = 32'h3333_4444;
    tick(); tick();
    bus.d_req = 1'b0;
    tick();
    for (int c = 0; c < 4; c++) begin
      bus.mem_ack = 1'b1; bus.mem_rdata = $urandom;
      tick();
      n_cmp++;
      if ({bus.i_ack, bus.d_ack, bus.mem_req, bus.busy} !== 4'b0000) begin n_bad++; $display("FAIL idle_ack c%0d: iack/dack/req/busy got %b want 0000", c, {bus.i_ack, bus.d_ack, bus.mem_req, bus.busy}); end
      n_cmp++;
      if (bus.i_rdata !== 32'h1111_2222 || bus.d_rdata !== 32'h3333_4444) begin n_bad++; $display("FAIL idle_rdata c%0d: got %h %h want 11112222 33334444", c, bus.i_rdata, bus.d_rdata); end
    end
    bus.mem_ack = 1'b0;
  endtask

  task automatic test_reset_mid_transaction();
    apply_reset();
    bus.i_req = 1'b1; bus.i_addr = 32'h50;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h30; bus.d_wdata = 32'hCAFE_0001;
    tick();
    n_cmp++; if ({bus.mem_req, bus.busy} !== 2'b11 || dut.starve_cnt_r !== 3'd1) begin n_bad++; $display("FAIL rm_pre: req/busy %b starve %0d want 11 1", {bus.mem_req, bus.busy}, dut.starve_cnt_r); end
    #2;
    reset = 1'b1;
    #1;
    n_cmp++; if ({bus.mem_req, bus.busy} !== 2'b00) begin n_bad++; $display("FAIL rm_async: req/busy got %b want 00", {bus.mem_req, bus.busy}); end
    bus.mem_ack = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_cmp++; if ({bus.d_ack, bus.i_ack} !== 2'b00) begin n_bad++; $display("FAIL rm_ack_in_reset c%0d: got %b want 00", c, {bus.d_ack, bus.i_ack}); end
    end
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++; if ({bus.d_ack, bus.i_ack, bus.mem_req, bus.busy} !== 4'b0000) begin n_bad++; $display("FAIL rm_after c%0d: dack/iack/req/busy got %b want 0000", c, {bus.d_ack, bus.i_ack, bus.mem_req, bus.busy}); end
      n_cmp++; if (dut.starve_cnt_r !== 3'd0) begin n_bad++; $display("FAIL rm_starve c%0d: got %0d want 0", c, dut.starve_cnt_r); end
    end
    bus.mem_ack = 1'b0;
  endtask

  task automatic test_random();
    logic i_pend, d_pend;
    apply_reset();
    model_reset();
    i_pend = 1'b0;
    d_pend = 1'b0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      // Fetch requester: holds req through the ack cycle, then drops or reissues.
      if (i_pend) begin
        i_pend = 1'b0;
        if ($urandom_range(0, 1) == 0) bus.i_req = 1'b0;
        else bus.i_addr = $urandom;
      end else if (!bus.i_req && $urandom_range(0, 2) == 0) begin
        bus.i_req = 1'b1; bus.i_addr = $urandom;
      end
      if (m_i_ack) i_pend = 1'b1;
      // Data requester, same discipline, random read/write.
      if (d_pend) begin
        d_pend = 1'b0;
        if ($urandom_range(0, 1) == 0) bus.d_req = 1'b0;
        else begin bus.d_we = 1'($urandom_range(0, 1)); bus.d_addr = $urandom; bus.d_wdata = $urandom; end
      end else if (!bus.d_req && $urandom_range(0, 1) == 0) begin
        bus.d_req = 1'b1; bus.d_we = 1'($urandom_range(0, 1)); bus.d_addr = $urandom; bus.d_wdata = $urandom;
      end
      if (m_d_ack) d_pend = 1'b1;
      bus.mem_ack = 1'($urandom_range(0, 1));
      bus.mem_rdata = $urandom;
      @(posedge clk);
      model_clock();
      #1;
      n_cmp++; if (bus.mem_req !== m_mem_req) begin n_bad++; $display("FAIL rnd_mem_req @%0d: got %b want %b", cyc, bus.mem_req, m_mem_req); end
      n_cmp++; if (bus.mem_we !== m_mem_we) begin n_bad++; $display("FAIL rnd_mem_we @%0d: got %b want %b", cyc, bus.mem_we, m_mem_we); end
      n_cmp++; if (bus.mem_addr !== m_mem_addr) begin n_bad++; $display("FAIL rnd_mem_addr @%0d: got %h want %h", cyc, bus.mem_addr, m_mem_addr); end
      n_cmp++; if (bus.mem_wdata !== m_mem_wdata) begin n_bad++; $display("FAIL rnd_mem_wdata @%0d: got %h want %h", cyc, bus.mem_wdata, m_mem_wdata); end
      n_cmp++; if (bus.i_ack !== m_i_ack) begin n_bad++; $display("FAIL rnd_i_ack @%0d: got %b want %b", cyc, bus.i_ack, m_i_ack); end
      n_cmp++; if (bus.d_ack !== m_d_ack) begin n_bad++; $display("FAIL rnd_d_ack @%0d: got %b want %b", cyc, bus.d_ack, m_d_ack); end
      n_cmp++; if (bus.i_rdata !== m_i_rdata) begin n_bad++; $display("FAIL rnd_i_rdata @%0d: got %h want %h", cyc, bus.i_rdata, m_i_rdata); end
      n_cmp++; if (bus.d_rdata !== m_d_rdata) begin n_bad++; $display("FAIL rnd_d_rdata @%0d: got %h want %h", cyc, bus.d_rdata, m_d_rdata); end
      n_cmp++; if (bus.busy !== (m_serving != 0)) begin n_bad++; $display("FAIL rnd_busy @%0d: got %b want %b", cyc, bus.busy, (m_serving != 0)); end
      n_cmp++; if (dut.starve_cnt_r !== 3'(m_starve)) begin n_bad++; $display("FAIL rnd_starve @%0d: got %0d want %0d", cyc, dut.starve_cnt_r, m_starve); end
    end
    bus.i_req = 1'b0; bus.d_req = 1'b0; bus.mem_ack = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    bus.i_req = 1'b0; bus.i_addr = 32'h0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = 32'h0; bus.d_wdata = 32'h0;
    bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
    test_reset();
    test_i_only();
    test_d_over_i();
    test_starvation_guard();
    test_wait_states();
    test_ack_while_idle();
    test_reset_mid_transaction();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
